// File: rtl/memory_access_controller_if.sv
// Request/response bundle between the load/store datapath and the memory access controller.
// The master side is the datapath plus RAM wrapper; the slave side is the controller.
interface memory_access_controller_if;
  logic        start;
  logic        isStore;
  logic [2:0]  funct3In;
  logic [31:0] rs1;
  logic [31:0] immediate;
  logic [31:0] ramDataOut;
  logic [2:0]  funct3;
  logic [29:0] backendAddress;
  logic [1:0]  offset;
  logic        ramWriteEnable;
  logic [31:0] loadData;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  faultCause;

  modport master (
    output start, isStore, funct3In, rs1, immediate, ramDataOut,
    input  funct3, backendAddress, offset, ramWriteEnable, loadData,
    input  busy, done, fault, faultCause
  );

  modport slave (
    input  start, isStore, funct3In, rs1, immediate, ramDataOut,
    output funct3, backendAddress, offset, ramWriteEnable, loadData,
    output busy, done, fault, faultCause
  );
endinterface

// File: rtl/memory_access_controller.sv
// Sequences one RISC-V load/store against a word-addressed RAM wrapper, with
// fault screening (illegal funct3, misalignment, out-of-range) at acceptance.
//
// state    | meaning
// IDLE     | waiting for start; request fields sampled on acceptance
// PRELOAD  | sb/sh: read the target word so the wrapper can merge bytes
// WRITE    | ramWriteEnable asserted for this single cycle
// READ     | load address presented to the RAM
// CAPTURE  | ramDataOut latched into loadData on the exit edge
// COMPLETE | done for one cycle, with fault/faultCause if the request faulted
module memory_access_controller #(
  parameter int RAM_A_WIDTH = 12
) (
  input logic clock,
  input logic reset,
  memory_access_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    WRITE,
    READ,
    CAPTURE,
    COMPLETE
  } state_t;

  state_t state, state_nxt;

  logic [31:0] ea;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  cause_nxt;

  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        is_store_q;
  logic [1:0]  cause_q;
  logic [31:0] load_q;

  assign ea     = bus.rs1 + bus.immediate;
  assign accept = (state == IDLE) && bus.start;

  // Screening works on the live inputs so the fault path can jump straight to COMPLETE.
  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    cause_nxt    = 2'b00;
    if (bus.isStore)
      illegal = !(bus.funct3In inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(bus.funct3In inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((bus.funct3In[1:0] == 2'b01) && ea[0]) ||
                   ((bus.funct3In == 3'b010) && (ea[1:0] != 2'b00));
    out_of_range = (ea[31:2] >> RAM_A_WIDTH) != 30'd0;
    if (illegal)           cause_nxt = 2'b11;
    else if (misaligned)   cause_nxt = 2'b01;
    else if (out_of_range) cause_nxt = 2'b10;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.ramWriteEnable = 1'b0;
    bus.busy           = 1'b1;
    bus.done           = 1'b0;
    bus.fault          = 1'b0;
    bus.faultCause     = 2'b00;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          if (cause_nxt != 2'b00)         state_nxt = COMPLETE;
          else if (!bus.isStore)          state_nxt = READ;
          else if (bus.funct3In == 3'b010) state_nxt = WRITE;
          else                            state_nxt = PRELOAD;
        end
      end
      PRELOAD: state_nxt = WRITE;
      WRITE: begin
        bus.ramWriteEnable = 1'b1;
        state_nxt          = COMPLETE;
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = COMPLETE;
      COMPLETE: begin
        bus.done       = 1'b1;
        bus.fault      = (cause_q != 2'b00);
        bus.faultCause = cause_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      is_store_q <= 1'b0;
      cause_q    <= '0;
      load_q     <= '0;
    end else begin
      if (accept) begin
        addr_q     <= ea[31:2];
        off_q      <= ea[1:0];
        f3_q       <= bus.funct3In;
        is_store_q <= bus.isStore;
        cause_q    <= cause_nxt;
      end
      if ((state == CAPTURE) && !is_store_q)
        load_q <= bus.ramDataOut;
    end
  end

  assign bus.backendAddress = addr_q;
  assign bus.offset         = off_q;
  assign bus.funct3         = f3_q;
  assign bus.loadData       = load_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller: loads, stores, faults, address wrap,
// start-while-busy and reset in the middle of a store.
module tb_memory_access_controller;
  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   w0;

  memory_access_controller_if mif ();

  memory_access_controller #(.RAM_A_WIDTH(12)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (mif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (mif.ramWriteEnable === 1'b1) wr_count++;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] r, input logic [31:0] i);
    mif.start     = 1'b1;
    mif.isStore   = st;
    mif.funct3In  = f3;
    mif.rs1       = r;
    mif.immediate = i;
  endtask

  task automatic fault_case(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] r, input logic [31:0] i, input logic [1:0] cause);
    issue(st, f3, r, i);
    mif.ramDataOut = 32'hCAFEF00D;
    w0 = wr_count;
    tick;
    mif.start = 1'b0;
    chk({tag, "_done"}, mif.done, 1);
    chk({tag, "_fault"}, mif.fault, 1);
    chk({tag, "_cause"}, mif.faultCause, cause);
    chk({tag, "_we"}, mif.ramWriteEnable, 0);
    chk({tag, "_load"}, mif.loadData, 32'hDEADBEEF);
    tick;
    chk({tag, "_idle_busy"}, mif.busy, 0);
    chk({tag, "_idle_fault"}, {mif.fault, mif.faultCause}, 0);
    chk({tag, "_writes"}, wr_count - w0, 0);
  endtask

  initial begin
    reset = 1'b1;
    mif.start = 1'b0; mif.isStore = 1'b0; mif.funct3In = 3'b000;
    mif.rs1 = '0; mif.immediate = '0; mif.ramDataOut = '0;
    #12;
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_fault", {mif.fault, mif.faultCause}, 0);
    chk("rst_we", mif.ramWriteEnable, 0);
    chk("rst_addr", {mif.backendAddress, mif.offset}, 0);
    chk("rst_f3", mif.funct3, 0);
    chk("rst_load", mif.loadData, 0);
    #8;
    reset = 1'b0;

    // lw 0x104: first edge after reset accepts
    issue(1'b0, 3'b010, 32'h100, 32'h4);
    mif.ramDataOut = 32'hDEADBEEF;
    tick;
    mif.start = 1'b0;
    chk("lw_c1_busy", mif.busy, 1);
    chk("lw_c1_done", mif.done, 0);
    chk("lw_addr", mif.backendAddress, 32'h41);
    chk("lw_off", mif.offset, 0);
    chk("lw_f3", mif.funct3, 3'b010);
    chk("lw_c1_we", mif.ramWriteEnable, 0);
    tick;
    chk("lw_c2_done", mif.done, 0);
    tick;
    chk("lw_c3_done", mif.done, 1);
    chk("lw_c3_fault", {mif.fault, mif.faultCause}, 0);
    chk("lw_load", mif.loadData, 32'hDEADBEEF);
    tick;
    chk("lw_idle_busy", mif.busy, 0);
    chk("lw_idle_done", mif.done, 0);

    fault_case("sh_mis", 1'b1, 3'b001, 32'h100, 32'h1, 2'b01);
    fault_case("lw_oor", 1'b0, 3'b010, 32'h4000, 32'h0, 2'b10);
    fault_case("st_ill", 1'b1, 3'b100, 32'h100, 32'h0, 2'b11);
    fault_case("ill_mis", 1'b1, 3'b011, 32'h100, 32'h1, 2'b11);
    fault_case("mis_oor", 1'b0, 3'b010, 32'h4000, 32'h1, 2'b01);

    // sb at 0x203: PRELOAD then WRITE
    issue(1'b1, 3'b000, 32'h203, 32'h0);
    w0 = wr_count;
    tick;
    mif.start = 1'b0;
    chk("sb_c1_we", mif.ramWriteEnable, 0);
    chk("sb_c1_busy", mif.busy, 1);
    chk("sb_off", mif.offset, 3);
    chk("sb_addr", mif.backendAddress, 32'h80);
    tick;
    chk("sb_c2_we", mif.ramWriteEnable, 1);
    chk("sb_c2_done", mif.done, 0);
    tick;
    chk("sb_c3_we", mif.ramWriteEnable, 0);
    chk("sb_c3_done", mif.done, 1);
    chk("sb_c3_fault", mif.fault, 0);
    tick;
    chk("sb_writes", wr_count - w0, 1);

    // sw at 0x14: straight to WRITE
    issue(1'b1, 3'b010, 32'h10, 32'h4);
    tick;
    mif.start = 1'b0;
    chk("sw_c1_we", mif.ramWriteEnable, 1);
    chk("sw_addr", mif.backendAddress, 32'h5);
    tick;
    chk("sw_c2_done", mif.done, 1);
    chk("sw_c2_we", mif.ramWriteEnable, 0);
    tick;

    // last legal word for a 12-bit RAM
    issue(1'b0, 3'b010, 32'h3FFC, 32'h0);
    mif.ramDataOut = 32'h0BADF00D;
    tick;
    mif.start = 1'b0;
    chk("top_addr", mif.backendAddress, 32'hFFF);
    tick;
    tick;
    chk("top_done", mif.done, 1);
    chk("top_fault", mif.fault, 0);
    chk("top_load", mif.loadData, 32'h0BADF00D);
    tick;

    // address wraps modulo 2^32
    issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'h8);
    mif.ramDataOut = 32'h55AA55AA;
    tick;
    mif.start = 1'b0;
    chk("wrap_addr", mif.backendAddress, 32'h1);
    chk("wrap_off", mif.offset, 0);
    tick;
    tick;
    chk("wrap_done", mif.done, 1);
    chk("wrap_fault", mif.fault, 0);
    chk("wrap_load", mif.loadData, 32'h55AA55AA);
    tick;

    // start during READ and during COMPLETE is ignored
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    mif.ramDataOut = 32'h11112222;
    tick;
    issue(1'b1, 3'b010, 32'h800, 32'h0);
    tick;
    mif.start = 1'b0;
    chk("ign_addr", mif.backendAddress, 32'h10);
    chk("ign_we", mif.ramWriteEnable, 0);
    tick;
    chk("ign_done", mif.done, 1);
    chk("ign_load", mif.loadData, 32'h11112222);
    issue(1'b1, 3'b010, 32'h900, 32'h0);
    tick;
    mif.start = 1'b0;
    chk("ign_cmp_busy", mif.busy, 0);
    chk("ign_cmp_addr", mif.backendAddress, 32'h10);
    tick;
    chk("ign_cmp_idle", mif.busy, 0);

    // reset in the middle of a sw
    issue(1'b1, 3'b010, 32'h30, 32'h0);
    tick;
    mif.start = 1'b0;
    chk("rw_we_before", mif.ramWriteEnable, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_we", mif.ramWriteEnable, 0);
    chk("rw_busy", mif.busy, 0);
    chk("rw_done", mif.done, 0);
    chk("rw_addr", mif.backendAddress, 0);
    #1;
    reset = 1'b0;
    issue(1'b0, 3'b000, 32'h21, 32'h3);
    mif.ramDataOut = 32'h000000AB;
    tick;
    mif.start = 1'b0;
    chk("rw_lb_busy", mif.busy, 1);
    chk("rw_lb_done", mif.done, 0);
    chk("rw_lb_addr", {mif.backendAddress, mif.offset}, 32'h24);
    tick;
    tick;
    chk("rw_lb_c3_done", mif.done, 1);
    chk("rw_lb_fault", mif.fault, 0);
    chk("rw_lb_load", mif.loadData, 32'h000000AB);
    tick;
    chk("rw_lb_idle", mif.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
